sr_excitation_driver: RTL and testbench

SR_EXCITATION_DRIVER -- requirements
Module: sr_excitation_driver

---
 rtl/sr_excitation_driver.sv | 131 +++++++++++++
 tb/tb_sr_excitation_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sr_excitation_driver.sv
// Drives S/R pulses into an external SR flip-flop to reach a requested Q,
// waits for the flop to settle, then checks Q/Qbar and keeps error statistics.
module sr_excitation_driver #(
    parameter int PULSE_CYCLES  = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic             s_out,
    output logic             r_out,
    input  logic             q_in,
    input  logic             qbar_in,
    output logic             done_valid,
    output logic             done_ok,
    output logic [ERR_W-1:0] err_count,
    output logic             illegal_flag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam logic [3:0] PULSE_LAST  = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam bit         NO_SETTLE   = (SETTLE_CYCLES == 0);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic             tgt_q;
    logic             s_q;
    logic             r_q;
    logic             done_valid_q;
    logic             done_ok_q;
    logic             illegal_q;
    logic [ERR_W-1:0] err_q;

    logic             accept_d;
    logic             pass_d;
    logic             enter_check_d;
    logic [ERR_W-1:0] err_d;

    assign tgt_ready = (state_q == IDLE) && rst_n;
    assign accept_d  = tgt_valid && tgt_ready;
    assign pass_d    = (q_in == tgt_q) && (qbar_in == ~tgt_q);
    assign err_d     = (err_q == '1) ? err_q : err_q + 1'b1;

    // Q/Qbar are sampled on the edge that enters CHECK so the result is
    // registered and presented together with done_valid.
    assign enter_check_d = (cnt_q == 4'd0) &&
                           ((state_q == SETTLE) || (state_q == DRIVE && NO_SETTLE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            tgt_q        <= 1'b0;
            s_q          <= 1'b0;
            r_q          <= 1'b0;
            done_valid_q <= 1'b0;
            done_ok_q    <= 1'b0;
            illegal_q    <= 1'b0;
            err_q        <= '0;
        end else begin
            done_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        tgt_q   <= tgt_bit;
                        s_q     <= ~q_in & tgt_bit;
                        r_q     <= q_in & ~tgt_bit;
                        cnt_q   <= PULSE_LAST;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_q == 4'd0) begin
                        s_q <= 1'b0;
                        r_q <= 1'b0;
                        if (NO_SETTLE) begin
                            state_q <= CHECK;
                        end else begin
                            cnt_q   <= SETTLE_LAST;
                            state_q <= SETTLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (enter_check_d) begin
                done_valid_q <= 1'b1;
                done_ok_q    <= pass_d;
                if (!pass_d) begin
                    err_q <= err_d;
                end
                if (q_in == qbar_in) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    assign s_out        = s_q;
    assign r_out        = r_q;
    assign done_valid   = done_valid_q;
    assign done_ok      = done_ok_q;
    assign err_count    = err_q;
    assign illegal_flag = illegal_q;

endmodule

// File: tb/tb_sr_excitation_driver.sv
// Bench for sr_excitation_driver: a behavioural SR flop closes the loop,
// table vectors plus a hand-written abort sequence, results via a scoreboard queue.
module tb_sr_excitation_driver;

    localparam int P = 1;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tgt_valid = 1'b0;
    logic       tgt_bit = 1'b0;
    logic       tgt_ready, s_out, r_out, done_valid, done_ok, illegal_flag;
    logic [7:0] err_count;
    logic       q_in, qbar_in;

    logic       tgt_ready2, s_out2, r_out2, done_valid2, done_ok2, illegal_flag2;
    logic [1:0] err_count2;

    // 0: flop model drives Q/Qbar, 1: stuck at Q=0, 2: illegal Q=Qbar=1
    logic [1:0] mode = 2'd0;
    logic       ff;
    logic       ff_load = 1'b0;
    logic       ff_init = 1'b0;

    int         n_chk = 0;
    int         n_err = 0;
    int         err_exp = 0;
    int         err2_exp = 0;
    logic       ill_exp = 1'b0;
    logic       sb[$];

    typedef struct {
        logic       init;
        logic       tgt;
        logic [1:0] md;
        logic       es;
        logic       er;
        logic       eok;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    assign q_in    = (mode == 2'd0) ? ff : ((mode == 2'd1) ? 1'b0 : 1'b1);
    assign qbar_in = (mode == 2'd0) ? ~ff : 1'b1;

    always @(posedge clk) begin
        if (ff_load)    ff <= ff_init;
        else if (s_out) ff <= 1'b1;
        else if (r_out) ff <= 1'b0;
    end

    sr_excitation_driver #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S), .ERR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready), .s_out(s_out), .r_out(r_out), .q_in(q_in),
        .qbar_in(qbar_in), .done_valid(done_valid), .done_ok(done_ok),
        .err_count(err_count), .illegal_flag(illegal_flag)
    );

    sr_excitation_driver #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready2), .s_out(s_out2), .r_out(r_out2), .q_in(q_in),
        .qbar_in(qbar_in), .done_valid(done_valid2), .done_ok(done_ok2),
        .err_count(err_count2), .illegal_flag(illegal_flag2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge during IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_txn(input vec_t v);
        logic ok_exp;
        mode = v.md;
        if (ff !== v.init) begin
            ff_init = v.init;
            ff_load = 1'b1;
            @(negedge clk);
            ff_load = 1'b0;
        end
        chk("ready_idle", 32'(tgt_ready), 32'(1'b1));
        tgt_valid = 1'b1;
        tgt_bit   = v.tgt;
        sb.push_back(v.eok);
        for (int k = 1; k <= P + S + 1; k++) begin
            @(negedge clk);
            tgt_bit = ~v.tgt;
            chk("ready_busy", 32'(tgt_ready), 32'(1'b0));
            chk("sr_excl", 32'(s_out & r_out), 32'(1'b0));
            if (k <= P) begin
                chk("drive_s", 32'(s_out), 32'(v.es));
                chk("drive_r", 32'(r_out), 32'(v.er));
                chk("dv_drive", 32'(done_valid), 32'(1'b0));
            end else if (k <= P + S) begin
                chk("settle_sr", 32'({s_out, r_out}), 32'(2'b00));
                chk("dv_settle", 32'(done_valid), 32'(1'b0));
            end else begin
                tgt_valid = 1'b0;
                chk("dv_check", 32'(done_valid), 32'(1'b1));
                chk("check_sr", 32'({s_out, r_out}), 32'(2'b00));
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'(0), 32'(1));
                end else begin
                    ok_exp = sb.pop_front();
                    chk("done_ok", 32'(done_ok), 32'(ok_exp));
                    if (!ok_exp) begin
                        if (err_exp < 255) err_exp++;
                        if (err2_exp < 3)  err2_exp++;
                    end
                end
                if (v.md == 2'd2) ill_exp = 1'b1;
                chk("err_count", 32'(err_count), 32'(err_exp));
                chk("err_count_w2", 32'(err_count2), 32'(err2_exp));
                chk("illegal", 32'(illegal_flag), 32'(ill_exp));
            end
        end
        @(negedge clk);
        chk("dv_idle", 32'(done_valid), 32'(1'b0));
        chk("ok_hold", 32'(done_ok), 32'(v.eok));
    endtask

    initial begin
        //            init tgt  md    s     r     ok
        vecs[0]  = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(tgt_ready), 32'(1'b0));
        chk("rst_sr", 32'({s_out, r_out}), 32'(2'b00));
        chk("rst_dv_ok", 32'({done_valid, done_ok}), 32'(2'b00));
        chk("rst_err", 32'(err_count), 32'(0));
        chk("rst_ill", 32'(illegal_flag), 32'(1'b0));
        rst_n = 1'b1;
        #1;
        chk("ready_release", 32'(tgt_ready), 32'(1'b1));

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i]);
        end

        // Abort a set request during DRIVE
        mode = 2'd0;
        ff_init = 1'b0;
        ff_load = 1'b1;
        @(negedge clk);
        ff_load = 1'b0;
        tgt_valid = 1'b1;
        tgt_bit   = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        chk("abort_drive_s", 32'(s_out), 32'(1'b1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_s", 32'({s_out, r_out}), 32'(2'b00));
        chk("abort_ready", 32'(tgt_ready), 32'(1'b0));
        chk("abort_err", 32'(err_count), 32'(0));
        chk("abort_ill", 32'(illegal_flag), 32'(1'b0));
        chk("abort_ok", 32'(done_ok), 32'(1'b0));
        err_exp  = 0;
        err2_exp = 0;
        ill_exp  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("abort_no_dv", 32'(done_valid), 32'(1'b0));
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        chk("ready_after_abort", 32'(tgt_ready), 32'(1'b1));
        // ff went to 1 from the single aborted S pulse; first edge after release accepts
        run_txn('{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1});
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
